// File: rtl/mem_core_fifo_drain.sv
// Read-side drain stage for memory_core in FIFO mode: credit-limited read issue, skid buffer, flush and error tracking.
// Optional delivered-word counter enabled by defining MEM_CORE_DRAIN_STATS_EN.
module mem_core_fifo_drain #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SKID_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic                  fifo_valid_out,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_ren,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            occupancy,
  output logic [3:0]            inflight,
  output logic                  err_sticky,
  output logic [31:0]           word_count
);

  localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic [CNT_W-1:0]      infl_q, infl_d;
  logic                  err_q, err_d;
  logic                  ren;
  logic                  push;
  logic                  pop;
  logic                  ret_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state, issue and buffer-control decode
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    err_d    = err_q;
    ren      = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    ret_ok   = fifo_valid_out && (infl_q != '0);

    if (fifo_valid_out && (infl_q == '0)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        ren  = enable && !flush && !fifo_empty &&
               ((SUM_W'(occ_q) + SUM_W'(infl_q)) < SUM_W'(SKID_DEPTH));
        pop  = (occ_q != '0) && out_ready;
        push = ret_ok;
        // Overflow drops the word; a simultaneous pop frees the slot it needs.
        if (push && (occ_q == CNT_W'(SKID_DEPTH)) && !pop) begin
          err_d = 1'b1;
          push  = 1'b0;
        end
        if (push) begin
          wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
          rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
        if (flush) begin
          state_d  = ST_FLUSH;
          occ_d    = '0;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
        end
      end
      ST_FLUSH: begin
        if (infl_q == '0) begin
          state_d = ST_RUN;
        end
      end
    endcase

    infl_d = infl_q + CNT_W'(ren) - CNT_W'(ret_ok);
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      infl_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      err_q    <= err_d;
    end
  end

  // Skid buffer storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= fifo_data_out;
    end
  end

  // Issue is held off while reset is asserted so the core sees no read during reset.
  assign fifo_ren   = ren && reset;
  assign out_valid  = (state_q == ST_RUN) && (occ_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign occupancy  = occ_q;
  assign inflight   = infl_q;
  assign err_sticky = err_q;

`ifdef MEM_CORE_DRAIN_STATS_EN
  logic [31:0] wc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wc_q <= '0;
    end else if (pop) begin
      wc_q <= wc_q + 32'd1;
    end
  end

  assign word_count = wc_q;
`else
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_mem_core_fifo_drain.sv
// Self-checking bench for mem_core_fifo_drain: cycle tables plus a latency-1 core model for streaming sequences.
module tb_mem_core_fifo_drain;

  typedef struct {
    logic        en;
    logic        emp;
    logic        vo;
    logic [15:0] d;
    logic        rdy;
    logic        fl;
    logic        ren;
    logic        ov;
    logic [15:0] od;
    logic [3:0]  occ;
    logic [3:0]  inf;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        t_en = 1'b0;
  logic        t_fl = 1'b0;
  logic        t_emp = 1'b1;
  logic        t_vo = 1'b0;
  logic [15:0] t_d = 16'h0;
  logic        t_rdy = 1'b0;

  logic        core_auto = 1'b0;
  logic        m_vo = 1'b0;
  logic [15:0] m_data = 16'h0;
  logic [15:0] core_mem [64];
  logic [5:0]  core_head = 6'd0;
  logic [5:0]  core_tail = 6'd0;

  logic        fifo_empty;
  logic        fifo_valid_out;
  logic [15:0] fifo_data_out;
  logic        fifo_ren;
  logic [15:0] out_data;
  logic        out_valid;
  logic [3:0]  occupancy;
  logic [3:0]  inflight;
  logic        err_sticky;
  logic [31:0] word_count;

  int checks = 0;
  int failures = 0;

  vec_t tbl [17];
  vec_t ftbl [14];
  vec_t atbl [5];

  always #5 clk = ~clk;

  assign fifo_empty     = core_auto ? (core_head == core_tail) : t_emp;
  assign fifo_valid_out = core_auto ? m_vo : t_vo;
  assign fifo_data_out  = core_auto ? m_data : t_d;

  // Core model with read latency 1
  always @(posedge clk) begin
    m_vo <= core_auto && fifo_ren;
    if (core_auto && fifo_ren) begin
      m_data    <= core_mem[core_head];
      core_head <= core_head + 6'd1;
    end
  end

  mem_core_fifo_drain #(.DATA_WIDTH(16), .SKID_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (t_en),
    .flush         (t_fl),
    .fifo_empty    (fifo_empty),
    .fifo_valid_out(fifo_valid_out),
    .fifo_data_out (fifo_data_out),
    .fifo_ren      (fifo_ren),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (t_rdy),
    .occupancy     (occupancy),
    .inflight      (inflight),
    .err_sticky    (err_sticky),
    .word_count    (word_count)
  );

  function automatic vec_t mk(input logic en, input logic emp, input logic vo, input logic [15:0] d,
                              input logic rdy, input logic fl, input logic ren, input logic ov,
                              input logic [15:0] od, input logic [3:0] occ, input logic [3:0] inf,
                              input logic err);
    vec_t v;
    v.en = en; v.emp = emp; v.vo = vo; v.d = d; v.rdy = rdy; v.fl = fl;
    v.ren = ren; v.ov = ov; v.od = od; v.occ = occ; v.inf = inf; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic apply_row(input vec_t v, input string tag);
    @(negedge clk);
    t_en = v.en; t_emp = v.emp; t_vo = v.vo; t_d = v.d; t_rdy = v.rdy; t_fl = v.fl;
    #1;
    chk({tag, "_ren"}, 32'(fifo_ren), 32'(v.ren));
    chk({tag, "_ov"}, 32'(out_valid), 32'(v.ov));
    if (v.ov) chk({tag, "_od"}, 32'(out_data), 32'(v.od));
    chk({tag, "_occ"}, 32'(occupancy), 32'(v.occ));
    chk({tag, "_inf"}, 32'(inflight), 32'(v.inf));
    chk({tag, "_err"}, 32'(err_sticky), 32'(v.err));
  endtask

  task automatic idle_inputs();
    t_en = 1'b0; t_emp = 1'b1; t_vo = 1'b0; t_d = 16'h0; t_rdy = 1'b0; t_fl = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got;
    int first;
    int last;
    int rcnt;
    logic [31:0] exp_wc;

    // Free-running fill, backpressure, spurious return, drop check
    tbl[0]  = mk(1, 1, 0, 16'h0,    0, 0,  0, 0, 16'h0,    4'd0, 4'd0, 0);
    tbl[1]  = mk(1, 0, 0, 16'h0,    0, 0,  1, 0, 16'h0,    4'd0, 4'd0, 0);
    tbl[2]  = mk(1, 0, 1, 16'hA001, 0, 0,  1, 0, 16'h0,    4'd0, 4'd1, 0);
    tbl[3]  = mk(1, 0, 1, 16'hA002, 0, 0,  1, 1, 16'hA001, 4'd1, 4'd1, 0);
    tbl[4]  = mk(1, 0, 1, 16'hA003, 0, 0,  1, 1, 16'hA001, 4'd2, 4'd1, 0);
    tbl[5]  = mk(1, 0, 1, 16'hA004, 0, 0,  0, 1, 16'hA001, 4'd3, 4'd1, 0);
    tbl[6]  = mk(1, 0, 0, 16'h0,    0, 0,  0, 1, 16'hA001, 4'd4, 4'd0, 0);
    tbl[7]  = mk(1, 0, 0, 16'h0,    1, 0,  0, 1, 16'hA001, 4'd4, 4'd0, 0);
    tbl[8]  = mk(1, 0, 0, 16'h0,    1, 0,  1, 1, 16'hA002, 4'd3, 4'd0, 0);
    tbl[9]  = mk(1, 0, 1, 16'hA005, 1, 0,  1, 1, 16'hA003, 4'd2, 4'd1, 0);
    tbl[10] = mk(0, 0, 1, 16'hA006, 0, 0,  0, 1, 16'hA004, 4'd2, 4'd1, 0);
    tbl[11] = mk(0, 0, 1, 16'hBAD0, 0, 0,  0, 1, 16'hA004, 4'd3, 4'd0, 0);
    tbl[12] = mk(0, 0, 0, 16'h0,    0, 0,  0, 1, 16'hA004, 4'd3, 4'd0, 1);
    tbl[13] = mk(0, 0, 0, 16'h0,    1, 0,  0, 1, 16'hA004, 4'd3, 4'd0, 1);
    tbl[14] = mk(0, 0, 0, 16'h0,    1, 0,  0, 1, 16'hA005, 4'd2, 4'd0, 1);
    tbl[15] = mk(0, 0, 0, 16'h0,    1, 0,  0, 1, 16'hA006, 4'd1, 4'd0, 1);
    tbl[16] = mk(0, 0, 0, 16'h0,    1, 0,  0, 0, 16'h0,    4'd0, 4'd0, 1);

    // Fill to occupancy 3 before an asynchronous reset
    atbl[0] = mk(1, 0, 0, 16'h0,    0, 0,  1, 0, 16'h0,    4'd0, 4'd0, 1);
    atbl[1] = mk(1, 0, 1, 16'hC001, 0, 0,  1, 0, 16'h0,    4'd0, 4'd1, 1);
    atbl[2] = mk(1, 0, 1, 16'hC002, 0, 0,  1, 1, 16'hC001, 4'd1, 4'd1, 1);
    atbl[3] = mk(1, 0, 1, 16'hC003, 0, 0,  1, 1, 16'hC001, 4'd2, 4'd1, 1);
    atbl[4] = mk(0, 0, 0, 16'h0,    0, 0,  0, 1, 16'hC001, 4'd3, 4'd1, 1);

    // Flush with two reads in flight, then a zero-inflight flush
    ftbl[0]  = mk(1, 0, 0, 16'h0,    0, 0,  1, 0, 16'h0,    4'd0, 4'd0, 0);
    ftbl[1]  = mk(1, 0, 0, 16'h0,    0, 0,  1, 0, 16'h0,    4'd0, 4'd1, 0);
    ftbl[2]  = mk(1, 0, 1, 16'hB001, 0, 0,  1, 0, 16'h0,    4'd0, 4'd2, 0);
    ftbl[3]  = mk(1, 0, 1, 16'hB002, 0, 0,  1, 1, 16'hB001, 4'd1, 4'd2, 0);
    ftbl[4]  = mk(0, 0, 0, 16'h0,    0, 0,  0, 1, 16'hB001, 4'd2, 4'd2, 0);
    ftbl[5]  = mk(1, 0, 0, 16'h0,    0, 1,  0, 1, 16'hB001, 4'd2, 4'd2, 0);
    ftbl[6]  = mk(1, 0, 0, 16'h0,    1, 0,  0, 0, 16'h0,    4'd0, 4'd2, 0);
    ftbl[7]  = mk(1, 0, 1, 16'hB003, 1, 1,  0, 0, 16'h0,    4'd0, 4'd2, 0);
    ftbl[8]  = mk(1, 0, 1, 16'hB004, 1, 0,  0, 0, 16'h0,    4'd0, 4'd1, 0);
    ftbl[9]  = mk(1, 0, 0, 16'h0,    1, 0,  0, 0, 16'h0,    4'd0, 4'd0, 0);
    ftbl[10] = mk(1, 0, 0, 16'h0,    1, 0,  1, 0, 16'h0,    4'd0, 4'd0, 0);
    ftbl[11] = mk(0, 0, 1, 16'hC001, 1, 1,  0, 0, 16'h0,    4'd0, 4'd1, 0);
    ftbl[12] = mk(1, 0, 0, 16'h0,    0, 0,  0, 0, 16'h0,    4'd0, 4'd0, 0);
    ftbl[13] = mk(1, 0, 0, 16'h0,    0, 0,  1, 0, 16'h0,    4'd0, 4'd0, 0);

    // Power-on reset values, observed before any clock edge
    t_en = 1'b1; t_emp = 1'b0;
    #1 reset = 1'b0;
    #2;
    chk("por_ren", 32'(fifo_ren), 32'd0);
    chk("por_ov", 32'(out_valid), 32'd0);
    chk("por_od", 32'(out_data), 32'd0);
    chk("por_occ", 32'(occupancy), 32'd0);
    chk("por_inf", 32'(inflight), 32'd0);
    chk("por_err", 32'(err_sticky), 32'd0);
    chk("por_wc", word_count, 32'd0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;

    for (int i = 0; i < 17; i++) apply_row(tbl[i], $sformatf("tbl%0d", i));
    for (int i = 0; i < 5; i++) apply_row(atbl[i], $sformatf("arst%0d", i));

    // Asynchronous reset between edges with three words buffered
    t_en = 1'b1; t_emp = 1'b0; t_rdy = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("arst_ren", 32'(fifo_ren), 32'd0);
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_od", 32'(out_data), 32'd0);
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_inf", 32'(inflight), 32'd0);
    chk("arst_err", 32'(err_sticky), 32'd0);
    chk("arst_wc", word_count, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    t_en = 1'b0; t_rdy = 1'b0; t_vo = 1'b1; t_d = 16'hC004;
    @(negedge clk);
    t_vo = 1'b0;
    #1;
    chk("late_return_err", 32'(err_sticky), 32'd1);
    chk("late_return_occ", 32'(occupancy), 32'd0);

    // Steady drain of six words through the core model
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      core_mem[core_tail] = 16'(i + 1);
      core_tail = core_tail + 6'd1;
    end
    core_auto = 1'b1; t_en = 1'b1; t_rdy = 1'b1;
    got = 0; first = -1; last = -1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (out_valid && t_rdy) begin
        chk($sformatf("drain_w%0d", got), 32'(out_data), 32'(got + 1));
        if (first < 0) first = k;
        last = k;
        got++;
      end
      @(negedge clk);
    end
    chk("drain_count", 32'(got), 32'd6);
    chk("drain_first_cycle", 32'(first), 32'd2);
    chk("drain_last_cycle", 32'(last), 32'd7);
    chk("drain_err", 32'(err_sticky), 32'd0);
`ifdef MEM_CORE_DRAIN_STATS_EN
    exp_wc = 32'd6;
`else
    exp_wc = 32'd0;
`endif
    chk("drain_word_count", word_count, exp_wc);

    // Backpressure with ten words available
    t_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      core_mem[core_tail] = 16'h0011 + 16'(i);
      core_tail = core_tail + 6'd1;
    end
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("bp_ren_bound%0d", k),
          32'(fifo_ren && ((5'(occupancy) + 5'(inflight)) >= 5'd4)), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("bp_occ", 32'(occupancy), 32'd4);
    chk("bp_inf", 32'(inflight), 32'd0);
    chk("bp_ren", 32'(fifo_ren), 32'd0);
    @(negedge clk);
    t_rdy = 1'b1;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (out_valid && t_rdy) begin
        chk($sformatf("bp_w%0d", got), 32'(out_data), 32'h11 + 32'(got));
        got++;
      end
      @(negedge clk);
    end
    chk("bp_count", 32'(got), 32'd10);
    chk("bp_err", 32'(err_sticky), 32'd0);

    // Empty boundary: no issue while empty, exactly one read for one word
    rcnt = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (fifo_ren) rcnt++;
      @(negedge clk);
    end
    chk("empty_no_ren", 32'(rcnt), 32'd0);
    core_mem[core_tail] = 16'h00E1;
    core_tail = core_tail + 6'd1;
    rcnt = 0; got = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (fifo_ren) rcnt++;
      if (out_valid && t_rdy) begin
        chk("empty_word", 32'(out_data), 32'h00E1);
        got++;
      end
      @(negedge clk);
    end
    chk("empty_one_ren", 32'(rcnt), 32'd1);
    chk("empty_one_word", 32'(got), 32'd1);

    // Flush sequences on direct-driven inputs
    core_auto = 1'b0;
    do_reset();
    for (int i = 0; i < 14; i++) apply_row(ftbl[i], $sformatf("flush%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
